ddr_axi_tester: RTL and testbench

AXI-style burst initiator that drives the user port of the DDR SDRAM controller as a write/read self-test master. It writes an address-derived pattern over a configurable region, reads the region back, and compares every beat. It also counts mismatches and protocol errors. It sits on the controller's core clock domain, between the controller's user port and board-level status LEDs/registers.

---
 rtl/ddr_axi_tester.sv | 255 +++++++++++++++++++++++++
 tb/tb_ddr_axi_tester.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_axi_tester.sv
// Write/read self-test master for the DDR controller user port: writes an
// address-derived pattern over a region, reads it back and counts bad beats.
module ddr_axi_tester #(
    parameter int BA_BITS    = 2,
    parameter int ROW_BITS   = 13,
    parameter int COL_BITS   = 11,
    parameter int DQ_LEVEL   = 1,
    parameter logic [BA_BITS+ROW_BITS+COL_BITS+DQ_LEVEL-2:0] START_ADDR = '0,
    parameter logic [7:0] BURST_LEN = 8'd7,
    parameter int NUM_BURSTS = 4,
    parameter int TIMEOUT    = 1024,
    localparam int AW = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1,
    localparam int DW = 8 << DQ_LEVEL
) (
    input  logic          core_clk,
    input  logic          core_rstn_sync,
    input  logic          start,
    input  logic          continuous,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          timeout,
    output logic [15:0]   err_count,
    output logic [15:0]   pass_count,
    output logic [2:0]    dbg_state,
    output logic          awvalid,
    input  logic          awready,
    output logic [AW-1:0] awaddr,
    output logic [7:0]    awlen,
    output logic          wvalid,
    input  logic          wready,
    output logic          wlast,
    output logic [DW-1:0] wdata,
    input  logic          bvalid,
    output logic          bready,
    output logic          arvalid,
    input  logic          arready,
    output logic [AW-1:0] araddr,
    output logic [7:0]    arlen,
    input  logic          rvalid,
    output logic          rready,
    input  logic          rlast,
    input  logic [DW-1:0] rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam int BCW = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [BCW-1:0] LAST_BURST  = BCW'(NUM_BURSTS - 1);
    localparam logic [WDW-1:0] WD_LIMIT    = WDW'(TIMEOUT - 1);
    localparam logic [AW-1:0]  BURST_BYTES = AW'((32'(BURST_LEN) + 32'd1) << DQ_LEVEL);
    localparam logic [AW-1:0]  BEAT_BYTES  = AW'(32'd1 << DQ_LEVEL);

    logic [2:0]     state_q, state_d;
    logic [BCW-1:0] burst_q, burst_d;
    logic [7:0]     beat_q, beat_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
    logic           bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic           busy_q, busy_d, done_q, done_d, error_q, error_d, timeout_q, timeout_d;
    logic [AW-1:0]  awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [7:0]     awlen_q, awlen_d, arlen_q, arlen_d;
    logic [DW-1:0]  wdata_q, wdata_d, exp_data;
    logic [15:0]    err_count_q, err_count_d, pass_count_q, pass_count_d;
    logic           hs, bad_beat, active;

    function automatic logic [AW-1:0] burst_base(input logic [BCW-1:0] b);
        return START_ADDR + AW'(b) * BURST_BYTES;
    endfunction

    // Beat byte address, low bits replicated across the data word; inverted on odd passes.
    function automatic logic [DW-1:0] beat_data(input logic [BCW-1:0] b, input logic [7:0] bt,
                                                input logic inv);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = burst_base(b) + AW'(bt) * BEAT_BYTES;
        for (int i = 0; i < DW; i++) d[i] = a[i % AW];
        return inv ? ~d : d;
    endfunction

    // A transfer happens on a clock edge where both valid and ready are high; every
    // valid raised here stays high with its address/data unchanged until that edge.
    always_comb begin
        state_d      = state_q;
        burst_d      = burst_q;
        beat_d       = beat_q;
        err_count_d  = err_count_q;
        pass_count_d = pass_count_q;
        error_d      = error_q;
        timeout_d    = timeout_q;
        hs           = 1'b0;
        bad_beat     = 1'b0;
        exp_data     = beat_data(burst_q, beat_q, pass_count_q[0]);
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_AW;
                burst_d = '0;
                beat_d  = '0;
            end
            S_AW: if (awvalid_q && awready) begin
                hs      = 1'b1;
                beat_d  = '0;
                state_d = S_W;
            end
            S_W: if (wvalid_q && wready) begin
                hs     = 1'b1;
                beat_d = beat_q + 8'd1;
                if (wlast_q) state_d = S_B;
            end
            S_B: if (bready_q && bvalid) begin
                hs = 1'b1;
                if (burst_q == LAST_BURST) begin
                    burst_d = '0;
                    state_d = S_AR;
                end else begin
                    burst_d = burst_q + 1'b1;
                    state_d = S_AW;
                end
            end
            S_AR: if (arvalid_q && arready) begin
                hs      = 1'b1;
                beat_d  = '0;
                state_d = S_R;
            end
            S_R: if (rready_q && rvalid) begin
                hs       = 1'b1;
                bad_beat = (rdata != exp_data) || (rlast != (beat_q == BURST_LEN));
                beat_d   = beat_q + 8'd1;
                // Burst length is ours to enforce; a stray rlast is only counted.
                if (beat_q == BURST_LEN) begin
                    if (burst_q == LAST_BURST) begin
                        state_d = S_DONE;
                    end else begin
                        burst_d = burst_q + 1'b1;
                        state_d = S_AR;
                    end
                end
            end
            S_DONE: begin
                burst_d = '0;
                beat_d  = '0;
                state_d = continuous ? S_AW : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        active = (state_q == S_AW) || (state_q == S_W) || (state_q == S_B) ||
                 (state_q == S_AR) || (state_q == S_R);
        wd_d = '0;
        if (active && !hs) begin
            if (wd_q == WD_LIMIT) begin
                state_d   = S_IDLE;
                timeout_d = 1'b1;
                error_d   = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end

        if (bad_beat) begin
            error_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
        end
        if (state_d == S_DONE) pass_count_d = pass_count_q + 16'd1;

        awvalid_d = (state_d == S_AW);
        awaddr_d  = (state_d == S_AW) ? burst_base(burst_d) : awaddr_q;
        awlen_d   = (state_d == S_AW) ? BURST_LEN : awlen_q;
        wvalid_d  = (state_d == S_W);
        wdata_d   = (state_d == S_W) ? beat_data(burst_d, beat_d, pass_count_d[0]) : wdata_q;
        wlast_d   = (state_d == S_W) && (beat_d == BURST_LEN);
        bready_d  = (state_d == S_B);
        arvalid_d = (state_d == S_AR);
        araddr_d  = (state_d == S_AR) ? burst_base(burst_d) : araddr_q;
        arlen_d   = (state_d == S_AR) ? BURST_LEN : arlen_q;
        rready_d  = (state_d == S_R);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge core_clk or negedge core_rstn_sync) begin
        if (!core_rstn_sync) begin
            state_q      <= S_IDLE;
            burst_q      <= '0;
            beat_q       <= '0;
            wd_q         <= '0;
            awvalid_q    <= 1'b0;
            awaddr_q     <= '0;
            awlen_q      <= '0;
            wvalid_q     <= 1'b0;
            wdata_q      <= '0;
            wlast_q      <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            rready_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            timeout_q    <= 1'b0;
            err_count_q  <= '0;
            pass_count_q <= '0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            beat_q       <= beat_d;
            wd_q         <= wd_d;
            awvalid_q    <= awvalid_d;
            awaddr_q     <= awaddr_d;
            awlen_q      <= awlen_d;
            wvalid_q     <= wvalid_d;
            wdata_q      <= wdata_d;
            wlast_q      <= wlast_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            rready_q     <= rready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            timeout_q    <= timeout_d;
            err_count_q  <= err_count_d;
            pass_count_q <= pass_count_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign timeout    = timeout_q;
    assign err_count  = err_count_q;
    assign pass_count = pass_count_q;
    assign dbg_state  = state_q;
    assign awvalid    = awvalid_q;
    assign awaddr     = awaddr_q;
    assign awlen      = awlen_q;
    assign wvalid     = wvalid_q;
    assign wlast      = wlast_q;
    assign wdata      = wdata_q;
    assign bready     = bready_q;
    assign arvalid    = arvalid_q;
    assign araddr     = araddr_q;
    assign arlen      = arlen_q;
    assign rready     = rready_q;

endmodule

// File: tb/tb_ddr_axi_tester.sv
// Directed bench for ddr_axi_tester: memory responder with stall, corruption,
// missing-response and early-rlast modes, checked by immediate assertions.
module tb_ddr_axi_tester;

    logic        clk, rst_n, start, continuous;
    logic        busy, done, error, timeout;
    logic [15:0] err_count, pass_count;
    logic [2:0]  dbg_state;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [25:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [15:0] wdata, rdata;

    ddr_axi_tester #(.TIMEOUT(16)) dut (
        .core_clk(clk), .core_rstn_sync(rst_n), .start(start), .continuous(continuous),
        .busy(busy), .done(done), .error(error), .timeout(timeout),
        .err_count(err_count), .pass_count(pass_count), .dbg_state(dbg_state),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Responder configuration and logs
    logic        stall_en = 1'b0, no_b = 1'b0, corrupt_en = 1'b0, early_rlast = 1'b0;
    logic        corrupt_out = 1'b0;
    logic [25:0] aw_log[$];
    logic [25:0] ar_log[$];
    logic [15:0] wd_log[$];
    int          done_cnt = 0, r_beats = 0, stall_viol = 0, cyc = 0;

    logic [15:0] mem [0:31];
    logic [25:0] wr_base, rd_base, a;
    int          wr_beat, rd_beat;
    logic        b_pend, rd_act, b_hold, r_hold;
    logic        aw_s, w_s, wlast_s, bready_s, ar_s, rready_s;
    logic [25:0] awaddr_s, araddr_s;
    logic [15:0] wdata_s;

    function automatic logic pick();
        return !stall_en || ($urandom_range(0, 1) == 1) || (cyc % 4 == 0);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
            rdata = '0; b_pend = 0; rd_act = 0; corrupt_out = 0;
            aw_s = 0; w_s = 0; wlast_s = 0; bready_s = 0; ar_s = 0; rready_s = 0;
            awaddr_s = '0; araddr_s = '0; wdata_s = '0; wr_base = '0; rd_base = '0;
            wr_beat = 0; rd_beat = 0;
        end else begin
            if (aw_s && !awready && (!awvalid || awaddr !== awaddr_s)) stall_viol++;
            if (w_s && !wready && (!wvalid || wdata !== wdata_s || wlast !== wlast_s)) stall_viol++;
            if (ar_s && !arready && (!arvalid || araddr !== araddr_s)) stall_viol++;
            b_hold = bvalid && !bready_s;
            r_hold = rvalid && !rready_s;
            if (aw_s && awready) begin
                aw_log.push_back(awaddr_s); wr_base = awaddr_s; wr_beat = 0;
            end
            if (w_s && wready) begin
                a = wr_base + 26'(wr_beat) * 26'd2;
                mem[a[5:1]] = wdata_s;
                wd_log.push_back(wdata_s);
                wr_beat++;
                if (wlast_s) b_pend = 1;
            end
            if (bvalid && bready_s) b_pend = 0;
            if (ar_s && arready) begin
                ar_log.push_back(araddr_s); rd_base = araddr_s; rd_beat = 0; rd_act = 1;
            end
            if (rvalid && rready_s) begin
                r_beats++; rd_beat++;
                if (rd_beat == 8) rd_act = 0;
            end
            awready = pick();
            wready  = pick();
            arready = pick();
            bvalid  = b_pend && !no_b && (b_hold || pick());
            rvalid  = rd_act && (r_hold || pick());
            a = rd_base + 26'(rd_beat) * 26'd2;
            rdata = mem[a[5:1]];
            corrupt_out = 0;
            if (corrupt_en && ar_log.size() == 3 && rd_beat == 3) begin
                rdata = rdata ^ 16'h0001;
                corrupt_out = rvalid;
            end
            rlast = (rd_beat == 7) || (early_rlast && ar_log.size() == 1 && rd_beat == 5);
            aw_s = awvalid; awaddr_s = awaddr; w_s = wvalid; wdata_s = wdata; wlast_s = wlast;
            bready_s = bready; ar_s = arvalid; araddr_s = araddr; rready_s = rready;
            if (done) done_cnt++;
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        repeat (3) tick();
        aw_log.delete(); ar_log.delete(); wd_log.delete();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {22'd0, awvalid, wvalid, wlast, bready, arvalid, rready,
                              busy, done, error, timeout}, 32'd0);
        check({tag, "_awaddr"}, 32'(awaddr), 32'd0);
        check({tag, "_araddr"}, 32'(araddr), 32'd0);
        check({tag, "_wdata"}, 32'(wdata), 32'd0);
        check({tag, "_lens"}, {16'd0, awlen, arlen}, 32'd0);
        check({tag, "_counts"}, {err_count, pass_count}, 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    task automatic check_region(input string tag);
        check({tag, "_aw_n"}, 32'(aw_log.size()), 32'd4);
        check({tag, "_ar_n"}, 32'(ar_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_awaddr%0d", tag, k), 32'(aw_log[k]), 32'(k * 16));
            check($sformatf("%s_araddr%0d", tag, k), 32'(ar_log[k]), 32'(k * 16));
        end
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_wdata%0d", tag, i), 32'(wd_log[i]), 32'(i * 2));
    endtask

    int d0, r0, s0, n;

    initial begin
        rst_n = 1'b0; start = 1'b0; continuous = 1'b0;
        repeat (2) tick();
        check_zero("reset");

        // Basic pass, always-ready responder
        do_reset();
        pulse_start();
        check("t1_aw_latency", {30'd0, awvalid, busy}, 32'd3);
        check("t1_awlen", 32'(awlen), 32'd7);
        d0 = done_cnt;
        wait_idle("t1_end", 1000);
        check("t1_done", 32'(done_cnt - d0), 32'd1);
        check("t1_counts", {err_count, pass_count}, {16'd0, 16'd1});
        check("t1_error", {31'd0, error}, 32'd0);
        check_region("t1");

        // Corrupted beat 3 of read burst 2
        do_reset();
        corrupt_en = 1'b1;
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (!corrupt_out && n < 500) begin tick(); n++; end
        check("t2_corrupt_seen", {31'd0, corrupt_out}, 32'd1);
        check("t2_rdata", 32'(rdata), 32'h27);
        check("t2_err_before", {15'd0, error, err_count}, 32'd0);
        tick();
        check("t2_err_after", {15'd0, error, err_count}, 32'h0001_0001);
        wait_idle("t2_end", 1000);
        corrupt_en = 1'b0;
        check("t2_done", 32'(done_cnt - d0), 32'd1);
        check("t2_err_final", 32'(err_count), 32'd1);

        // Two continuous passes; second writes the inverted pattern
        do_reset();
        continuous = 1'b1;
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (done_cnt - d0 < 1 && n < 1000) begin tick(); n++; end
        check("t3_first_done", 32'(done_cnt - d0), 32'd1);
        tick();
        continuous = 1'b0;
        check("t3_restart", {31'd0, awvalid}, 32'd1);
        wait_idle("t3_end", 1000);
        check("t3_done", 32'(done_cnt - d0), 32'd2);
        check("t3_counts", {error, 15'd0, err_count, pass_count}, {16'd0, 16'd2});
        check("t3_wd_n", 32'(wd_log.size()), 32'd64);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_p0_wdata%0d", i), 32'(wd_log[i]), 32'(i * 2));
            check($sformatf("t3_p1_wdata%0d", i), 32'(wd_log[32 + i]), 32'(16'hFFFF - 16'(i * 2)));
        end

        // Random stalls on every responder-side handshake
        do_reset();
        stall_en = 1'b1;
        s0 = stall_viol; r0 = r_beats; d0 = done_cnt;
        pulse_start();
        wait_idle("t4_end", 3000);
        stall_en = 1'b0;
        check("t4_stable", 32'(stall_viol - s0), 32'd0);
        check("t4_rbeats", 32'(r_beats - r0), 32'd32);
        check("t4_done", 32'(done_cnt - d0), 32'd1);
        check("t4_counts", {err_count, pass_count}, {16'd0, 16'd1});
        check_region("t4");

        // Missing write response: watchdog expiry in B
        do_reset();
        no_b = 1'b1;
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (!bready && n < 100) begin tick(); n++; end
        check("t5_in_b", {31'd0, bready}, 32'd1);
        check("t5_to_early", {30'd0, timeout, error}, 32'd0);
        repeat (15) tick();
        check("t5_to_15", {30'd0, timeout, bready}, 32'd1);
        tick();
        check("t5_to_16", {30'd0, timeout, error}, 32'd3);
        check("t5_quiet", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        no_b = 1'b0;

        // rlast early on beat 5 of read burst 0
        do_reset();
        early_rlast = 1'b1;
        r0 = r_beats; d0 = done_cnt;
        pulse_start();
        wait_idle("t6_end", 1000);
        early_rlast = 1'b0;
        check("t6_err", {15'd0, error, err_count}, 32'h0001_0001);
        check("t6_rbeats", 32'(r_beats - r0), 32'd32);
        check("t6_ar_n", 32'(ar_log.size()), 32'd4);
        check("t6_done", 32'(done_cnt - d0), 32'd1);

        // Reset asserted in the middle of a write burst
        do_reset();
        pulse_start();
        n = 0;
        while (!wvalid && n < 50) begin tick(); n++; end
        tick();
        tick();
        check("t7_in_w", {31'd0, wvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("t7_midw");
        tick();
        rst_n = 1'b1;
        tick();
        check("t7_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
